// File: rtl/stack_call_ctrl.sv
// Call/return sequencer for the 8-bit hardware stack: pushes PC+1 and jumps on CALL,
// pops and reloads the PC on RET, tracking depth so over/underflow never reach the stack.
module stack_call_ctrl #(
   parameter int DEPTH  = 16,
   parameter int RD_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       call,
   input  logic       ret,
   input  logic [7:0] target,
   input  logic [7:0] pc,
   input  logic       clr_err,
   output logic       stk_push,
   output logic       stk_pop,
   output logic [7:0] stk_value,
   input  logic [7:0] stk_data,
   output logic       pc_load,
   output logic [7:0] pc_next,
   output logic       busy,
   output logic [7:0] depth,
   output logic       overflow,
   output logic       underflow
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PUSH = 3'd1;
   localparam logic [2:0] S_POP  = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_LOAD = 3'd4;

   localparam logic [7:0] DEPTH_MAX = 8'(DEPTH);
   localparam logic [2:0] LAT       = 3'(RD_LAT);

   logic [2:0] r_state;
   logic [7:0] r_ret_addr;
   logic [7:0] r_target;
   logic [2:0] r_cnt;
   logic [7:0] r_pop_data;
   logic       r_ovf_evt;
   logic       r_unf_evt;

   logic       r_stk_push;
   logic       r_stk_pop;
   logic [7:0] r_stk_value;
   logic       r_pc_load;
   logic [7:0] r_pc_next;
   logic       r_busy;
   logic [7:0] r_depth;
   logic       r_overflow;
   logic       r_underflow;

   logic w_call_req;
   logic w_ret_req;

   // Simultaneous call and ret cancel each other out.
   assign w_call_req = call && !ret;
   assign w_ret_req  = ret && !call;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_ret_addr  <= 8'h00;
         r_target    <= 8'h00;
         r_cnt       <= 3'd0;
         r_pop_data  <= 8'h00;
         r_ovf_evt   <= 1'b0;
         r_unf_evt   <= 1'b0;
         r_stk_push  <= 1'b0;
         r_stk_pop   <= 1'b0;
         r_stk_value <= 8'h00;
         r_pc_load   <= 1'b0;
         r_pc_next   <= 8'h00;
         r_busy      <= 1'b0;
         r_depth     <= 8'h00;
      end else begin
         r_stk_push <= 1'b0;
         r_stk_pop  <= 1'b0;
         r_pc_load  <= 1'b0;
         r_ovf_evt  <= 1'b0;
         r_unf_evt  <= 1'b0;
         r_busy     <= (r_state != S_IDLE);
         case (r_state)
            S_IDLE: begin
               if (w_call_req) begin
                  if (r_depth < DEPTH_MAX) begin
                     r_ret_addr <= pc + 8'd1;
                     r_target   <= target;
                     r_state    <= S_PUSH;
                  end else begin
                     r_ovf_evt <= 1'b1;
                  end
               end else if (w_ret_req) begin
                  if (r_depth != 8'h00) begin
                     r_state <= S_POP;
                  end else begin
                     r_unf_evt <= 1'b1;
                  end
               end
            end
            S_PUSH: begin
               r_stk_push  <= 1'b1;
               r_stk_value <= r_ret_addr;
               r_pc_load   <= 1'b1;
               r_pc_next   <= r_target;
               r_depth     <= r_depth + 8'd1;
               r_state     <= S_IDLE;
            end
            S_POP: begin
               r_stk_pop <= 1'b1;
               r_depth   <= r_depth - 8'd1;
               r_cnt     <= LAT;
               r_state   <= S_WAIT;
            end
            S_WAIT: begin
               // The counter value 1 marks the edge at which the stack data is valid.
               if (r_cnt == 3'd1) begin
                  r_pop_data <= stk_data;
                  r_state    <= S_LOAD;
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            S_LOAD: begin
               r_pc_load <= 1'b1;
               r_pc_next <= r_pop_data;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Flags rise one edge after the rejected request; a new error beats clr_err.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (r_ovf_evt) begin
            r_overflow <= 1'b1;
         end else if (clr_err) begin
            r_overflow <= 1'b0;
         end
         if (r_unf_evt) begin
            r_underflow <= 1'b1;
         end else if (clr_err) begin
            r_underflow <= 1'b0;
         end
      end
   end

   assign stk_push  = r_stk_push;
   assign stk_pop   = r_stk_pop;
   assign stk_value = r_stk_value;
   assign pc_load   = r_pc_load;
   assign pc_next   = r_pc_next;
   assign busy      = r_busy;
   assign depth     = r_depth;
   assign overflow  = r_overflow;
   assign underflow = r_underflow;

endmodule
